// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared types and constants for the trace dump path
//
// Purpose: dump FSM state encoding, header byte value and default capture depth.
// Ports:   none (package).
// Config:  TRACE_DUMP_HDR_EN adds the HDR0/HDR1 header states.
package capture_pkg;

  localparam int         DUMP_ENTRIES  = 384;
  localparam logic [7:0] DUMP_HDR_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    RD,
    RD_WAIT,
    SEND,
    TX_GUARD,
    TX_WAIT,
    DONE
`ifdef TRACE_DUMP_HDR_EN
    , HDR0,
    HDR1
`endif
  } dump_state_t;

endpackage

// File: rtl/wrap_addr_cnt.sv
// rtl/wrap_addr_cnt.sv - circular address counter with modulo-ENTRIES wrap
//
// Purpose: holds a read pointer that can be loaded or stepped; stepping from
//          ENTRIES-1 returns to 0, so ENTRIES need not be a power of two.
// Ports:   clk, rst      clock and synchronous active-high reset
//          load/load_val load cnt with load_val (wins over inc)
//          inc           advance cnt by one with wrap
//          cnt           current pointer value
module wrap_addr_cnt
  import capture_pkg::*;
#(
  parameter int ENTRIES = DUMP_ENTRIES,
  parameter int ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] cnt
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ENTRIES - 1);

  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/trace_dump.sv
// rtl/trace_dump.sv - streams a captured trace from RAM to a UART, oldest first
//
// Purpose: on an accepted dump_req, reads ENTRIES samples starting just after
//          the newest one (trace_end) and hands each byte to the UART with a
//          tx_start/tx_busy handshake.
// Ports:   clk, rst                      clock, synchronous active-high reset
//          dump_req/dump_chan/dump_abort  dump control
//          capture_done, trace_end        capture status and newest address
//          ram_en/ram_addr/ram_chan       RAM read port (data on ram_rdata next cycle)
//          tx_data/tx_start/tx_busy       UART byte interface
//          dump_busy/dump_done/clr_capture_done/dump_err  status pulses
// Config:  TRACE_DUMP_HDR_EN prefixes each dump with 8'hA5 and the channel byte.
module trace_dump
  import capture_pkg::*;
#(
  parameter int ENTRIES = DUMP_ENTRIES,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_req,
  input  logic [1:0]        dump_chan,
  input  logic              dump_abort,
  input  logic              capture_done,
  input  logic [ADDR_W-1:0] trace_end,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              tx_busy,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [1:0]        ram_chan,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  output logic              dump_busy,
  output logic              dump_done,
  output logic              clr_capture_done,
  output logic              dump_err
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ENTRIES - 1);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [1:0]        chan_q, chan_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              err_q, err_d;

  logic              ptr_load;
  logic              ptr_inc;
  logic [ADDR_W-1:0] ptr_load_val;
  logic [ADDR_W-1:0] rd_ptr;

`ifdef TRACE_DUMP_HDR_EN
  // Which byte the shared SEND/TX_GUARD/TX_WAIT path is carrying.
  localparam logic [1:0] PH_HDR0 = 2'd0;
  localparam logic [1:0] PH_HDR1 = 2'd1;
  localparam logic [1:0] PH_DATA = 2'd2;
  logic [1:0] phase_q, phase_d;
`endif

  wrap_addr_cnt #(
    .ENTRIES (ENTRIES),
    .ADDR_W  (ADDR_W)
  ) u_rd_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (ptr_load),
    .load_val (ptr_load_val),
    .inc      (ptr_inc),
    .cnt      (rd_ptr)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    chan_d       = chan_q;
    tx_data_d    = tx_data_q;
    err_d        = 1'b0;
    ptr_load     = 1'b0;
    ptr_inc      = 1'b0;
    // Oldest sample sits just after the newest one in the circular buffer.
    ptr_load_val = (trace_end == LAST_IDX) ? '0 : trace_end + ADDR_W'(1);
`ifdef TRACE_DUMP_HDR_EN
    phase_d      = phase_q;
`endif

    case (state_q)
      IDLE: begin
        if (dump_req) begin
          if (capture_done) begin
            chan_d   = dump_chan;
            count_d  = '0;
            ptr_load = 1'b1;
`ifdef TRACE_DUMP_HDR_EN
            state_d  = HDR0;
`else
            state_d  = RD;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
`ifdef TRACE_DUMP_HDR_EN
      HDR0: begin
        tx_data_d = DATA_W'(DUMP_HDR_BYTE);
        phase_d   = PH_HDR0;
        state_d   = SEND;
      end
      HDR1: begin
        tx_data_d = DATA_W'(chan_q);
        phase_d   = PH_HDR1;
        state_d   = SEND;
      end
`endif
      RD:       state_d = RD_WAIT;
      RD_WAIT: begin
        tx_data_d = ram_rdata;
        state_d   = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          state_d = TX_GUARD;
        end
      end
      // The UART raises tx_busy one cycle after tx_start; skip that cycle.
      TX_GUARD: state_d = TX_WAIT;
      TX_WAIT: begin
        if (!tx_busy) begin
`ifdef TRACE_DUMP_HDR_EN
          if (phase_q == PH_HDR0) begin
            state_d = HDR1;
          end else if (phase_q == PH_HDR1) begin
            phase_d = PH_DATA;
            state_d = RD;
          end else
`endif
          begin
            count_d = count_q + ADDR_W'(1);
            ptr_inc = 1'b1;
            state_d = (count_q == LAST_IDX) ? DONE : RD;
          end
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Abort overrides any transition chosen above.
    if (dump_abort && (state_q != IDLE)) begin
      state_d = IDLE;
      ptr_inc = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      chan_q    <= '0;
      tx_data_q <= '0;
      err_q     <= 1'b0;
`ifdef TRACE_DUMP_HDR_EN
      phase_q   <= PH_HDR0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      chan_q    <= chan_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
`ifdef TRACE_DUMP_HDR_EN
      phase_q   <= phase_d;
`endif
    end
  end

  assign ram_en           = (state_q == RD);
  assign ram_addr         = rd_ptr;
  assign ram_chan         = chan_q;
  assign tx_data          = tx_data_q;
  // Combinational so a same-cycle abort cannot swallow the launch pulse.
  assign tx_start         = (state_q == SEND) && !tx_busy;
  assign dump_busy        = (state_q != IDLE);
  assign dump_done        = (state_q == DONE);
  assign clr_capture_done = (state_q == DONE);
  assign dump_err         = err_q;

endmodule

// File: tb/tb_trace_dump.sv
// tb/tb_trace_dump.sv - directed self-checking bench for trace_dump
module tb_trace_dump;

  localparam int ENTRIES = 384;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 8;
`ifdef TRACE_DUMP_HDR_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              dump_req;
  logic [1:0]        dump_chan;
  logic              dump_abort;
  logic              capture_done;
  logic [ADDR_W-1:0] trace_end;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic              tx_busy;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_chan;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              dump_busy;
  logic              dump_done;
  logic              clr_capture_done;
  logic              dump_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]        byte_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  int                done_cnt, clr_cnt, err_cnt, busy_viol, stab_viol, chan_viol;
  logic [1:0]        exp_chan = 2'd0;
  logic [7:0]        last_tx = 8'd0;
  bit                uart_slow = 1'b0;
  int                busy_left = 0;

  trace_dump #(
    .ENTRIES (ENTRIES),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .dump_req         (dump_req),
    .dump_chan        (dump_chan),
    .dump_abort       (dump_abort),
    .capture_done     (capture_done),
    .trace_end        (trace_end),
    .ram_rdata        (ram_rdata),
    .tx_busy          (tx_busy),
    .ram_en           (ram_en),
    .ram_addr         (ram_addr),
    .ram_chan         (ram_chan),
    .tx_data          (tx_data),
    .tx_start         (tx_start),
    .dump_busy        (dump_busy),
    .dump_done        (dump_done),
    .clr_capture_done (clr_capture_done),
    .dump_err         (dump_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [1:0] ch, input int addr);
    return 8'((addr * 5) + (int'(ch) * 64) + 19);
  endfunction

  // RAM model: one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) ram_rdata <= pat(ram_chan, int'(ram_addr));
  end

  // UART model: busy for 20 cycles, rising one cycle after tx_start.
  always @(posedge clk) begin
    if (rst) busy_left <= 0;
    else if (tx_start && uart_slow) busy_left <= 20;
    else if (busy_left > 0) busy_left <= busy_left - 1;
  end
  assign tx_busy = (busy_left != 0);

  always @(negedge clk) begin
    if (ram_en) begin
      addr_q.push_back(ram_addr);
      if (ram_chan != exp_chan) chan_viol++;
    end
    if (tx_start) begin
      byte_q.push_back(tx_data);
      last_tx = tx_data;
      if (tx_busy) busy_viol++;
    end else if (tx_busy && tx_data != last_tx) begin
      stab_viol++;
    end
    if (dump_done) done_cnt++;
    if (clr_capture_done) clr_cnt++;
    if (dump_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clear_mon();
    byte_q.delete();
    addr_q.delete();
    done_cnt  = 0;
    clr_cnt   = 0;
    err_cnt   = 0;
    busy_viol = 0;
    stab_viol = 0;
    chan_viol = 0;
  endtask

  task automatic start_dump(input logic [1:0] ch, input int te);
    @(negedge clk);
    exp_chan  = ch;
    dump_chan = ch;
    trace_end = ADDR_W'(te);
    dump_req  = 1'b1;
    @(negedge clk);
    dump_req  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic verify_dump(input logic [1:0] ch, input int te);
    int am, dm;
    am = 0;
    dm = 0;
    check("byte_count", byte_q.size(), ENTRIES + HDR);
    check("addr_count", addr_q.size(), ENTRIES);
    if (addr_q.size() == ENTRIES) begin
      check("first_addr", addr_q[0], (te + 1) % ENTRIES);
      check("last_addr", addr_q[ENTRIES-1], te);
      for (int k = 0; k < ENTRIES; k++)
        if (int'(addr_q[k]) != (te + 1 + k) % ENTRIES) am++;
      check("addr_seq_errs", am, 0);
    end
    if (byte_q.size() == ENTRIES + HDR) begin
      for (int k = 0; k < ENTRIES; k++)
        if (byte_q[k+HDR] != pat(ch, (te + 1 + k) % ENTRIES)) dm++;
      check("data_errs", dm, 0);
`ifdef TRACE_DUMP_HDR_EN
      check("hdr_byte0", byte_q[0], 8'hA5);
      check("hdr_byte1", byte_q[1], {6'b0, ch});
`endif
    end
    check("done_pulses", done_cnt, 1);
    check("clr_pulses", clr_cnt, 1);
    check("err_pulses", err_cnt, 0);
    check("ram_chan_errs", chan_viol, 0);
    check("busy_after_done", dump_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    dump_req     = 1'b0;
    dump_chan    = 2'd0;
    dump_abort   = 1'b0;
    capture_done = 1'b0;
    trace_end    = '0;
    clear_mon();
    repeat (4) @(negedge clk);
    rst = 1'b0;

    // Reset values
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_chan", ram_chan, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_dump_busy", dump_busy, 0);
    check("rst_done", dump_done, 0);
    check("rst_clr", clr_capture_done, 0);
    check("rst_err", dump_err, 0);

    // Rejected request: error pulse next cycle, no activity
    start_dump(2'd1, 10);
    check("err_pulse", dump_err, 1);
    check("err_busy", dump_busy, 0);
    @(negedge clk);
    check("err_one_cycle", dump_err, 0);
    repeat (5) @(negedge clk);
    check("err_count", err_cnt, 1);
    check("err_no_ram_en", addr_q.size(), 0);
    clear_mon();

    // Normal dump with wrap; stray request and capture_done drop mid-dump
    capture_done = 1'b1;
    start_dump(2'd1, 10);
    check("busy_after_req", dump_busy, 1);
    repeat (300) @(negedge clk);
    dump_chan    = 2'd3;
    trace_end    = '0;
    dump_req     = 1'b1;
    @(negedge clk);
    dump_req     = 1'b0;
    capture_done = 1'b0;
    wait_done(5000);
    verify_dump(2'd1, 10);
    clear_mon();

    // Newest sample at the top address: no wrap inside the dump
    capture_done = 1'b1;
    start_dump(2'd0, 383);
    wait_done(5000);
    verify_dump(2'd0, 383);
    clear_mon();

    // Slow UART: no launch while busy, tx_data held per byte
    uart_slow = 1'b1;
    start_dump(2'd2, 100);
    wait_done(20000);
    verify_dump(2'd2, 100);
    check("start_while_busy", busy_viol, 0);
    check("tx_data_unstable", stab_viol, 0);
    uart_slow = 1'b0;
    repeat (25) @(negedge clk);
    clear_mon();

    // Abort after byte 50, then restart
    start_dump(2'd3, 200);
    for (int i = 0; i < 2000 && byte_q.size() < 50 + HDR; i++) @(negedge clk);
    dump_abort = 1'b1;
    @(negedge clk);
    dump_abort = 1'b0;
    check("abort_idle", dump_busy, 0);
    check("abort_bytes", byte_q.size(), 50 + HDR);
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_no_clr", clr_cnt, 0);
    clear_mon();
    start_dump(2'd3, 200);
    wait_done(5000);
    verify_dump(2'd3, 200);
    clear_mon();

    // Reset mid-dump
    start_dump(2'd1, 5);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", dump_busy, 0);
    check("midrst_addr", ram_addr, 0);
    check("midrst_chan", ram_chan, 0);
    check("midrst_tx_data", tx_data, 0);
    repeat (20) @(negedge clk);
    check("midrst_no_done", done_cnt, 0);
    check("midrst_no_err", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
